// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC producing Q2.30 cosine/sine of an integer-degree angle.
// One computation in flight; results are held until the next one completes.
module cordic_sincos #(
  parameter int ITER = 24
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] angl,
  input  logic [31:0] angle_in,
  output logic [31:0] cos_out,
  output logic [31:0] sin_out
);

  localparam logic signed [33:0] K_INIT = 34'sh0_26DD_3B6A;
  localparam logic signed [33:0] SAT_HI = 34'sh0_7FFF_FFFF;
  localparam logic signed [33:0] SAT_LO = 34'sh3_8000_0000;

  typedef enum logic [1:0] {IDLE, PREP, ROT, DONE} state_t;

  state_t             state;
  logic signed [32:0] a;
  logic signed [33:0] x, y;
  logic signed [31:0] z;
  logic [4:0]         iter;
  logic               neg;

  logic signed [32:0] wrapped, folded;
  logic               fold_neg;
  logic signed [31:0] t_cur, z_nxt;
  logic signed [33:0] x_sh, y_sh, x_nxt, y_nxt, x_fin, y_fin;

  // round(atan(2^-i) degrees * 2^16); entries past 22 round to zero
  function automatic logic signed [31:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_lut = 32'sh002D_0000;
      5'd1:    atan_lut = 32'sh001A_90A7;
      5'd2:    atan_lut = 32'sh000E_0947;
      5'd3:    atan_lut = 32'sh0007_2001;
      5'd4:    atan_lut = 32'sh0003_938B;
      5'd5:    atan_lut = 32'sh0001_CA38;
      5'd6:    atan_lut = 32'sh0000_E52A;
      5'd7:    atan_lut = 32'sh0000_7297;
      5'd8:    atan_lut = 32'sh0000_394C;
      5'd9:    atan_lut = 32'sh0000_1CA6;
      5'd10:   atan_lut = 32'sh0000_0E53;
      5'd11:   atan_lut = 32'sh0000_0729;
      5'd12:   atan_lut = 32'sh0000_0395;
      5'd13:   atan_lut = 32'sh0000_01CA;
      5'd14:   atan_lut = 32'sh0000_00E5;
      5'd15:   atan_lut = 32'sh0000_0073;
      5'd16:   atan_lut = 32'sh0000_0039;
      5'd17:   atan_lut = 32'sh0000_001D;
      5'd18:   atan_lut = 32'sh0000_000E;
      5'd19:   atan_lut = 32'sh0000_0007;
      5'd20:   atan_lut = 32'sh0000_0004;
      5'd21:   atan_lut = 32'sh0000_0002;
      5'd22:   atan_lut = 32'sh0000_0001;
      default: atan_lut = '0;
    endcase
  endfunction

  function automatic logic [31:0] sat32(input logic signed [33:0] v);
    if (v > SAT_HI)      sat32 = 32'h7FFF_FFFF;
    else if (v < SAT_LO) sat32 = 32'h8000_0000;
    else                 sat32 = v[31:0];
  endfunction

  // Wrap into [-180,180), then fold into [-90,90] and remember the sign flip
  always_comb begin
    wrapped = a;
    for (int unsigned k = 0; k < 2; k++) begin
      if (wrapped >= 33'sd180)       wrapped = wrapped - 33'sd360;
      else if (wrapped < -33'sd180)  wrapped = wrapped + 33'sd360;
    end
    folded   = wrapped;
    fold_neg = 1'b0;
    if (wrapped > 33'sd90) begin
      folded   = wrapped - 33'sd180;
      fold_neg = 1'b1;
    end else if (wrapped < -33'sd90) begin
      folded   = wrapped + 33'sd180;
      fold_neg = 1'b1;
    end
  end

  always_comb begin
    t_cur = atan_lut(iter);
    x_sh  = x >>> iter;
    y_sh  = y >>> iter;
    if (!z[31]) begin
      x_nxt = x - y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - t_cur;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + t_cur;
    end
    x_fin = neg ? -x : x;
    y_fin = neg ? -y : y;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      a       <= '0;
      x       <= '0;
      y       <= '0;
      z       <= '0;
      iter    <= '0;
      neg     <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a     <= {angle_in[31], angle_in} + {angl[31], angl};
            state <= PREP;
          end
        end
        PREP: begin
          z     <= 32'(folded <<< 16);
          x     <= K_INIT;
          y     <= '0;
          neg   <= fold_neg;
          iter  <= '0;
          state <= ROT;
        end
        ROT: begin
          x    <= x_nxt;
          y    <= y_nxt;
          z    <= z_nxt;
          iter <= iter + 5'd1;
          if (iter == 5'(ITER - 1)) state <= DONE;
        end
        DONE: begin
          cos_out <= sat32(x_fin);
          sin_out <= sat32(y_fin);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sincos.sv
// Bench for cordic_sincos: real-arithmetic transaction model checked every cycle,
// plus directed vectors with hand-computed Q2.30 expectations.
module tb_cordic_sincos;

  localparam int     ITER = 24;
  localparam longint TOL  = 2048;
  localparam int     ONE  = 1073741824;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [31:0] angl, angle_in;
  logic [31:0] cos_out, sin_out;

  int n_checks = 0;
  int n_pass   = 0;

  cordic_sincos #(.ITER(ITER)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .angl    (angl),
    .angle_in(angle_in),
    .cos_out (cos_out),
    .sin_out (sin_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp, input longint tol);
    longint diff;
    diff = longint'(act) - longint'(exp);
    if (diff < 0) diff = -diff;
    n_checks++;
    if (diff <= tol) n_pass++;
    else $display("FAIL %s: got %0d (0x%08h), want %0d +/- %0d", name, act, act, exp, tol);
  endtask

  // Ideal Q2.30 cos/sin of an integer-degree angle
  function automatic void ideal(input int deg, output int c, output int s);
    real r;
    r = real'(deg) * 3.14159265358979323846 / 180.0;
    c = int'(longint'($cos(r) * 1073741824.0));
    s = int'(longint'($sin(r) * 1073741824.0));
  endfunction

  // Transaction model: accept when free, publish result ITER+2 edges after acceptance
  int m_cnt = 0, m_pend = 0, m_cos = 0, m_sin = 0;
  bit m_live = 1'b0, m_exact = 1'b1;

  initial begin
    forever begin
      @(posedge clock);
      if (reset) begin
        m_cnt = 0; m_cos = 0; m_sin = 0; m_exact = 1'b1; m_live = 1'b1;
      end else if (m_cnt == 0) begin
        if (start && m_live) begin
          m_pend = $signed(angle_in) + $signed(angl);
          m_cnt  = ITER + 2;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          ideal(m_pend, m_cos, m_sin);
          m_exact = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (m_live) begin
        check("model_cos", cos_out, m_cos, m_exact ? 64'd0 : TOL);
        check("model_sin", sin_out, sin_out == sin_out ? m_sin : m_sin, m_exact ? 64'd0 : TOL);
      end
    end
  end

  task automatic run_vec(input int a, input int o, input int ec, input int es);
    @(negedge clock);
    angle_in = a; angl = o; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; angle_in = -a; angl = 17;
    repeat (ITER + 2) @(posedge clock);
    @(negedge clock);
    check($sformatf("vec_cos(%0d+%0d)", a, o), cos_out, ec, TOL);
    check($sformatf("vec_sin(%0d+%0d)", a, o), sin_out, es, TOL);
  endtask

  int va[12] = '{45, 0, 30, 180, -90, 300, 360, -360, -180, 100, -100, 90};
  int vo[12] = '{45, 0,  0,   0,   0, 200, 360, -360,    0,   0,    0,  0};
  int vc[12] = '{0, ONE, 929887698, -ONE, 0, -822533958, ONE, ONE, -ONE, -186453311, -186453311, 0};
  int vs[12] = '{ONE, 0, 536870912, 0, -ONE, 690187940, 0, 0, 0, 1057429273, -1057429273, ONE};

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, s;
    reset = 1'b1; start = 1'b0; angl = '0; angle_in = '0;

    ideal(90, c, s);  check("pin_sin90", s, ONE, 0);
    ideal(140, c, s); check("pin_cos140", c, -822533958, 2);
    ideal(30, c, s);  check("pin_sin30", s, 536870912, 1);

    repeat (3) @(negedge clock);
    check("reset_cos", cos_out, 0, 0);
    check("reset_sin", sin_out, 0, 0);
    reset = 1'b0;

    for (int k = 0; k < 12; k++) run_vec(va[k], vo[k], vc[k], vs[k]);

    // start held high with inputs changing every cycle
    @(negedge clock);
    start = 1'b1; angle_in = 10; angl = 0;
    for (int k = 0; k < 3 * (ITER + 3) + 2; k++) begin
      @(negedge clock);
      angle_in = (k * 37) % 300 - 150;
      angl     = k % 20;
    end
    start = 1'b0;
    repeat (ITER + 4) @(negedge clock);

    // reset in the middle of a rotation, then immediate restart
    run_vec(30, 0, 929887698, 536870912);
    @(negedge clock);
    angle_in = 60; angl = 0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("abort_cos", cos_out, 0, 0);
    check("abort_sin", sin_out, 0, 0);
    reset = 1'b0; start = 1'b1; angle_in = -45; angl = 0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (ITER + 2) @(posedge clock);
    @(negedge clock);
    check("restart_cos", cos_out, 759250125, TOL);
    check("restart_sin", sin_out, -759250125, TOL);

    repeat (4) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
